// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// A fetch entry packs {pc, inst} into one 64-bit word for the fetch buffer.
package inst_fetch_unit_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t ZERO_WORD    = '0;
  localparam logic  CHIP_ENABLE  = 1'b1;
  localparam logic  CHIP_DISABLE = 1'b0;

  localparam int FETCH_FIFO_DEPTH = 4;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  // Branch targets are forced onto a word boundary before they reach the PC.
  function automatic inst_addr_t align_word(input inst_addr_t addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous fetch buffer of {pc, inst} entries with push/pop/flush and occupancy count.
// The head is read straight from storage, so an entry is visible the cycle after its push.
module inst_fetch_unit_fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             head_valid,
  output fetch_entry_t     head_data,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A full buffer refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok    = push & ~flush & (count < DEPTH_CNT);
  assign pop_ok     = pop & head_valid;
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : {ZERO_WORD, ZERO_WORD};

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the combinational ROM and
// buffers fetched {pc, inst} pairs toward the decoder behind a valid/ready handshake.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter inst_addr_t RESET_PC   = 32'h0000_0000,
  parameter int         FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter int         FIFO_PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  branch_flag_i,
  input  logic [31:0]           branch_target_i,
  output logic                  rom_ce_o,
  output logic [31:0]           rom_addr_o,
  input  logic [31:0]           rom_inst_i,
  output logic                  id_valid_o,
  output logic [31:0]           id_pc_o,
  output logic [31:0]           id_inst_o,
  input  logic                  id_ready_i,
  output logic                  misalign_o,
  output logic [FIFO_PTR_W:0]   fifo_count_o
);

  localparam logic [FIFO_PTR_W:0] DEPTH_CNT = (FIFO_PTR_W+1)'(FIFO_DEPTH);

  logic         ce_q;
  inst_addr_t   pc_q;
  logic         misalign_q;
  logic         fetch_fire;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // A redirect or a stall suppresses the fetch; a redirect also flushes the buffer.
  assign fetch_fire = (ce_q == CHIP_ENABLE) & ~stall_i & ~branch_flag_i
                      & (fifo_count_o < DEPTH_CNT);
  assign pop        = id_valid_o & id_ready_i;
  assign push_entry = '{pc: pc_q, inst: rom_inst_i};

  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign id_pc_o    = head_entry.pc;
  assign id_inst_o  = head_entry.inst;
  assign misalign_o = misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q <= CHIP_DISABLE;
    end else begin
      ce_q <= CHIP_ENABLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (branch_flag_i) begin
      pc_q <= align_word(branch_target_i);
    end else if (fetch_fire) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= branch_flag_i & (branch_target_i[1:0] != 2'b00);
    end
  end

  inst_fetch_unit_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (FIFO_PTR_W)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fetch_fire),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (branch_flag_i),
    .head_valid (id_valid_o),
    .head_data  (head_entry),
    .count      (fifo_count_o)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed-vector bench for inst_fetch_unit with a combinational ROM model
// and hand-computed expected PC/count/valid sequences.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
  logic        misalign_o;
  logic [2:0]  fifo_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        ready;
    logic        exp_ce;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [2:0]  exp_count;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4),
    .FIFO_PTR_W (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_ready_i      (id_ready_i),
    .misalign_o      (misalign_o),
    .fifo_count_o    (fifo_count_o)
  );

  function automatic logic [31:0] romWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign rom_inst_i = romWord(rom_addr_o);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] tgt,
                              input logic rdy, input logic ce, input logic vld,
                              input logic [31:0] addr, input logic [31:0] pc,
                              input logic [2:0] cnt, input logic mis);
    vec_t v;
    v.stall = st; v.branch = br; v.target = tgt; v.ready = rdy;
    v.exp_ce = ce; v.exp_valid = vld; v.exp_addr = addr; v.exp_pc = pc;
    v.exp_count = cnt; v.exp_mis = mis;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int step,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, step, actual, expected);
    end
  endtask

  task automatic checkAll(input int step, input logic ce, input logic vld,
                          input logic [31:0] addr, input logic [31:0] pc,
                          input logic [2:0] cnt, input logic mis);
    logic [31:0] exp_inst;
    exp_inst = vld ? romWord(pc) : 32'h0;
    checkOutput("rom_ce",   step, {31'b0, rom_ce_o},     {31'b0, ce});
    checkOutput("rom_addr", step, rom_addr_o,            addr);
    checkOutput("id_valid", step, {31'b0, id_valid_o},   {31'b0, vld});
    checkOutput("id_pc",    step, id_pc_o,               vld ? pc : 32'h0);
    checkOutput("id_inst",  step, id_inst_o,             exp_inst);
    checkOutput("count",    step, {29'b0, fifo_count_o}, {29'b0, cnt});
    checkOutput("misalign", step, {31'b0, misalign_o},   {31'b0, mis});
  endtask

  task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt,
                               input logic rdy);
    stall_i         = st;
    branch_flag_i   = br;
    branch_target_i = tgt;
    id_ready_i      = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    stall_i         = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    id_ready_i      = 1'b0;

    // stall, branch, target, ready | ce, valid, addr, head pc, count, misalign
    vecs.push_back(mk(0,0,32'h0,1,        1,0,32'h0000_0000,32'h0000_0000,3'd0,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'h0000_0004,32'h0000_0000,3'd1,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'h0000_0008,32'h0000_0004,3'd1,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'h0000_000C,32'h0000_0008,3'd1,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0010,32'h0000_0008,3'd2,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0014,32'h0000_0008,3'd3,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0018,32'h0000_0008,3'd4,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0018,32'h0000_0008,3'd4,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0018,32'h0000_0008,3'd4,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'h0000_0018,32'h0000_000C,3'd3,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'h0000_001C,32'h0000_0010,3'd3,0));
    vecs.push_back(mk(1,0,32'h0,1,        1,1,32'h0000_001C,32'h0000_0014,3'd2,0));
    vecs.push_back(mk(1,0,32'h0,1,        1,1,32'h0000_001C,32'h0000_0018,3'd1,0));
    vecs.push_back(mk(1,0,32'h0,1,        1,0,32'h0000_001C,32'h0000_0000,3'd0,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0020,32'h0000_001C,3'd1,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0024,32'h0000_001C,3'd2,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0028,32'h0000_001C,3'd3,0));
    vecs.push_back(mk(0,1,32'h0000_0100,1,1,0,32'h0000_0100,32'h0000_0000,3'd0,0));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0104,32'h0000_0100,3'd1,0));
    vecs.push_back(mk(1,1,32'h0000_0103,0,1,0,32'h0000_0100,32'h0000_0000,3'd0,1));
    vecs.push_back(mk(0,0,32'h0,0,        1,1,32'h0000_0104,32'h0000_0100,3'd1,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'h0000_0108,32'h0000_0104,3'd1,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFF8,1,1,0,32'hFFFF_FFF8,32'h0000_0000,3'd0,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'hFFFF_FFFC,32'hFFFF_FFF8,3'd1,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'h0000_0000,32'hFFFF_FFFC,3'd1,0));
    vecs.push_back(mk(0,0,32'h0,1,        1,1,32'h0000_0004,32'h0000_0000,3'd1,0));

    #12;
    checkAll(-1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stall, vecs[i].branch, vecs[i].target, vecs[i].ready);
      checkAll(i, vecs[i].exp_ce, vecs[i].exp_valid, vecs[i].exp_addr,
               vecs[i].exp_pc, vecs[i].exp_count, vecs[i].exp_mis);
    end

    // Fill the buffer, then hit it with an asynchronous reset between edges.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    end
    checkAll(100, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 3'd4, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkAll(101, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);

    // Branch asserted while reset is held must leave no trace.
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0203;
    @(posedge clk);
    #1;
    checkAll(102, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    branch_flag_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkAll(103, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkAll(104, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000, 3'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkAll(105, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0004, 3'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch front end: owns the PC, drives the combinational instruction ROM (ce/addr in, inst out same cycle) and buffers fetched {pc, inst} pairs in a small FIFO toward the IF/ID boundary.
- Decouples the decoder with a valid/ready handshake.
- Absorbs pipeline stalls and branch redirects, flushing stale fetches.
- Sits between the ROM and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- FIFO_DEPTH, 4, fetch buffer entries; power of two, 2..16.
- FIFO_PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall_i  input  1  hold fetch from pipeline control; no PC advance, no push.
- branch_flag_i  input  1  redirect request this cycle.
- branch_target_i  input  32  redirect byte address.
- rom_ce_o  output  1  ROM chip enable; `ChipEnable when fetching.
- rom_addr_o  output  32  ROM byte address; equals pc.
- rom_inst_i  input  32  ROM data; combinational from rom_addr_o.
- id_valid_o  output  1  FIFO head valid.
- id_pc_o  output  32  PC of head entry.
- id_inst_o  output  32  instruction of head entry.
- id_ready_i  input  1  decoder accepts head this cycle.
- misalign_o  output  1  one-cycle pulse: redirect target had addr[1:0] != 0.
- fifo_count_o  output  FIFO_PTR_W+1  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, rom_ce_o=0.
  - FIFO empty (rd/wr ptr=0, count=0), id_valid_o=0.
  - id_pc_o=0, id_inst_o=0 (zero-word), misalign_o=0.
- Fetch enable:
  - ce register goes 1 at the first rising edge after reset deassertion, so the first fetch occurs in cycle 2 after release.
  - ce stays 1 thereafter.
- rom_addr_o = pc continuously; rom_ce_o = ce register.
- fetch_fire = ce & ~stall_i & ~branch_flag_i & (count < FIFO_DEPTH).
  - When true, {pc, rom_inst_i} is written at wr_ptr and pc <= pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - When false, pc holds.
- pop = id_valid_o & id_ready_i; rd_ptr advances.
  - Head outputs are registered storage reads; valid in the same cycle the entry exists (no bubble beyond 1-cycle push latency).
- Latency: PC X fetched at edge N is visible at id_* after edge N (available cycle N+1).
- Simultaneous push and pop: count unchanged; legal when full (a pop frees the slot only next cycle; a full FIFO blocks a push even with concurrent pop — decided, no bypass).
- Empty FIFO with push: id_valid_o rises next cycle; no combinational ROM-to-ID path.
- Pointer wrap: modulo FIFO_DEPTH; count distinguishes full from empty.
- Branch redirect (branch_flag_i=1), regardless of stall_i:
  - pc <= {branch_target_i[31:2], 2'b00}.
  - FIFO flushed (ptrs and count to 0); no push that cycle.
  - id_valid_o=0 next cycle, even if pop was asserted (the popped entry is counted consumed).
  - misalign_o=1 for the following cycle iff branch_target_i[1:0] != 0.
- Stall with no branch: PC and FIFO write side frozen; pop still allowed.
- Branch during reset: ignored. Reset mid-operation clears all state immediately, asynchronously.
- ce=0: no push, pc held.

Decomposition:
- Shared define file supplies `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable/`ChipDisable, and the new `FetchFifoDepth default.
- One sub-module: fetch_fifo (synchronous FIFO, 64-bit entries, push/pop/flush, count).
- The PC/ce logic stays in the top module.

Test Plan:
- Reset release, id_ready_i=1, no stall -> rom_ce_o=1 after first edge; id_pc_o sequence 0x0,0x4,0x8 on consecutive cycles with matching ROM words; fifo_count_o stays at most 1.
- id_ready_i=0 for 10 cycles -> count saturates at 4 holding PCs 0x0..0xC; pc holds at 0x10; releasing ready drains in order with no loss or duplication.
- stall_i=1 for 3 cycles mid-stream -> pc frozen, no pushes, pops continue; resume fetching the next sequential PC.
- branch_flag_i=1, target 0x0000_0100, FIFO holding 3 entries -> next cycle id_valid_o=0, count=0; the following cycle id_pc_o=0x100.
- Target 0x0000_0103 -> pc=0x100, misalign_o pulses exactly 1 cycle.
- rst asserted asynchronously between edges with a full FIFO -> outputs reach reset values without a clock edge; after release fetch restarts at RESET_PC.
